// File: rtl/spu32_cpu_alu_ext_pkg.sv
// Shared definitions for the spu32 execute unit: operation codes,
// FSM state encodings and small opcode-class helpers.
package spu32_cpu_alu_ext_pkg;

  localparam logic [4:0] ALUOP_ADD    = 5'd0;
  localparam logic [4:0] ALUOP_SUB    = 5'd1;
  localparam logic [4:0] ALUOP_AND    = 5'd2;
  localparam logic [4:0] ALUOP_OR     = 5'd3;
  localparam logic [4:0] ALUOP_XOR    = 5'd4;
  localparam logic [4:0] ALUOP_SLT    = 5'd5;
  localparam logic [4:0] ALUOP_SLTU   = 5'd6;
  localparam logic [4:0] ALUOP_SLL    = 5'd7;
  localparam logic [4:0] ALUOP_SRL    = 5'd8;
  localparam logic [4:0] ALUOP_SRA    = 5'd9;
  localparam logic [4:0] ALUOP_MUL    = 5'd10;
  localparam logic [4:0] ALUOP_MULH   = 5'd11;
  localparam logic [4:0] ALUOP_MULHSU = 5'd12;
  localparam logic [4:0] ALUOP_MULHU  = 5'd13;
  localparam logic [4:0] ALUOP_DIV    = 5'd14;
  localparam logic [4:0] ALUOP_DIVU   = 5'd15;
  localparam logic [4:0] ALUOP_REM    = 5'd16;
  localparam logic [4:0] ALUOP_REMU   = 5'd17;

  // Divider sequencing: capture -> XLEN restoring steps -> sign fix-up
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  // Serial shifter: one bit per clock while in SH_RUN
  typedef enum logic {
    SH_IDLE = 1'b0,
    SH_RUN  = 1'b1
  } shift_state_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return op inside {ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU};
  endfunction

  function automatic logic is_mul_op(input logic [4:0] op);
    return op inside {ALUOP_MUL, ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU};
  endfunction

  function automatic logic is_shift_op(input logic [4:0] op);
    return op inside {ALUOP_SLL, ALUOP_SRL, ALUOP_SRA};
  endfunction

endpackage

// File: rtl/spu32_cpu_alu_ext_divider.sv
// Iterative restoring divider. Operands are reduced to magnitudes at start,
// XLEN quotient bits are produced one per clock, and the FIX cycle applies
// the RISC-V sign and divide-by-zero rules combinationally so the parent
// can write the result on that same edge. State is held in 'state'.
module spu32_cpu_divider
  import spu32_cpu_alu_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  div_state_t      state, state_next;
  logic [XLEN-1:0] q, r, mag_b;
  logic [CW-1:0]   count;
  logic            neg_q, neg_r, b_zero;

  logic            neg_a_in, neg_b_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic [XLEN:0]   r_shift, trial;

  // Operand magnitudes and one restoring step (trial[XLEN] set means borrow)
  always_comb begin
    neg_a_in = signed_op & dividend[XLEN-1];
    neg_b_in = signed_op & divisor[XLEN-1];
    mag_a_in = neg_a_in ? -dividend : dividend;
    mag_b_in = neg_b_in ? -divisor : divisor;
    r_shift  = {r, q[XLEN-1]};
    trial    = r_shift - {1'b0, mag_b};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: fixed latency, no early-out
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (start) state_next = DIV_RUN;
      DIV_RUN:  if (count == '0) state_next = DIV_FIX;
      DIV_FIX:  state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Outputs: busy through FIX, result valid during FIX
  always_comb begin
    busy      = (state != DIV_IDLE);
    done      = (state == DIV_FIX);
    quotient  = b_zero ? '1 : (neg_q ? -q : q);
    remainder = neg_r ? -r : r;
  end

  // Datapath: capture at start, shift/subtract during RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      r      <= '0;
      mag_b  <= '0;
      count  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      q      <= mag_a_in;
      r      <= '0;
      mag_b  <= mag_b_in;
      count  <= CW'(XLEN - 1);
      neg_q  <= neg_a_in ^ neg_b_in;
      neg_r  <= neg_a_in;
      b_zero <= (divisor == '0);
    end else if (state == DIV_RUN) begin
      if (!trial[XLEN]) begin
        r <= trial[XLEN-1:0];
        q <= {q[XLEN-2:0], 1'b1};
      end else begin
        r <= r_shift[XLEN-1:0];
        q <= {q[XLEN-2:0], 1'b0};
      end
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/spu32_cpu_alu_ext.sv
// spu32 execute unit. Handshake: a request is taken on a rising edge where
// I_en=1, O_busy=0 and I_reset=0; every taken request yields exactly one
// O_valid pulse with the result in O_data (held until the next result),
// except that reset aborts any request in flight without a pulse.
module spu32_cpu_alu_ext
  import spu32_cpu_alu_ext_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 0,
  parameter int ENABLE_DIV   = 1
) (
  input  logic            I_clk,
  input  logic            I_reset,
  input  logic            I_en,
  input  logic [4:0]      I_aluop,
  input  logic [XLEN-1:0] I_dataS1,
  input  logic [XLEN-1:0] I_dataS2,
  output logic            O_busy,
  output logic            O_valid,
  output logic [XLEN-1:0] O_data,
  output logic            O_lt,
  output logic            O_ltu,
  output logic            O_eq
);

  localparam int SHW = $clog2(XLEN);

  logic              accept;
  logic [SHW-1:0]    shamt;
  logic              op_div, op_mul, op_sshift;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   alu_result;

  logic              mul_a_signed, mul_b_signed;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] mul_full;
  logic [2*XLEN-1:0] mul_prod;
  logic              mul_pending, mul_high;

  shift_state_t      sh_state, sh_state_next;
  logic [XLEN-1:0]   sh_val, sh_step;
  logic [SHW-1:0]    sh_cnt;
  logic              sh_left, sh_arith, sh_busy, sh_done;

  logic              div_busy, div_done, div_rem, div_signed;
  logic [XLEN-1:0]   div_quot, div_remd;

  assign accept = I_en && !O_busy && !I_reset;
  assign O_busy = mul_pending | sh_busy | div_busy;

  // Branch flags from the XLEN+1-bit difference of the live operands
  always_comb begin
    diff  = {1'b0, I_dataS1} - {1'b0, I_dataS2};
    O_ltu = diff[XLEN];
    O_eq  = (diff == '0);
    O_lt  = (I_dataS1[XLEN-1] ^ I_dataS2[XLEN-1]) ? I_dataS1[XLEN-1] : diff[XLEN];
  end

  // Request classification and single-cycle results (unknown ops add)
  always_comb begin
    shamt     = I_dataS2[SHW-1:0];
    op_div    = (ENABLE_DIV != 0) && is_div_op(I_aluop);
    op_mul    = is_mul_op(I_aluop);
    op_sshift = (SERIAL_SHIFT != 0) && is_shift_op(I_aluop) && (shamt != '0);
    case (I_aluop)
      ALUOP_SUB:  alu_result = I_dataS1 - I_dataS2;
      ALUOP_AND:  alu_result = I_dataS1 & I_dataS2;
      ALUOP_OR:   alu_result = I_dataS1 | I_dataS2;
      ALUOP_XOR:  alu_result = I_dataS1 ^ I_dataS2;
      ALUOP_SLT:  alu_result = {{(XLEN-1){1'b0}}, O_lt};
      ALUOP_SLTU: alu_result = {{(XLEN-1){1'b0}}, O_ltu};
      ALUOP_SLL:  alu_result = I_dataS1 << shamt;
      ALUOP_SRL:  alu_result = I_dataS1 >> shamt;
      ALUOP_SRA:  alu_result = $signed(I_dataS1) >>> shamt;
      default:    alu_result = I_dataS1 + I_dataS2;
    endcase
  end

  // Multiplier stage 1 operands: one extra bit carries each operand's signedness
  always_comb begin
    mul_a_signed = (I_aluop == ALUOP_MULH) || (I_aluop == ALUOP_MULHSU);
    mul_b_signed = (I_aluop == ALUOP_MULH);
    mul_a        = {mul_a_signed & I_dataS1[XLEN-1], I_dataS1};
    mul_b        = {mul_b_signed & I_dataS2[XLEN-1], I_dataS2};
    mul_full     = mul_a * mul_b;
    div_signed   = (I_aluop == ALUOP_DIV) || (I_aluop == ALUOP_REM);
  end

  // Serial shifter state register
  always_ff @(posedge I_clk) begin
    if (I_reset) sh_state <= SH_IDLE;
    else         sh_state <= sh_state_next;
  end

  // Serial shifter next state: run until the last remaining bit is shifted
  always_comb begin
    sh_state_next = sh_state;
    case (sh_state)
      SH_IDLE: if (accept && op_sshift) sh_state_next = SH_RUN;
      SH_RUN:  if (sh_cnt == SHW'(1)) sh_state_next = SH_IDLE;
      default: sh_state_next = SH_IDLE;
    endcase
  end

  // Serial shifter outputs and the one-bit step
  always_comb begin
    sh_busy = (sh_state == SH_RUN);
    sh_done = (sh_state == SH_RUN) && (sh_cnt == SHW'(1));
    sh_step = sh_left ? {sh_val[XLEN-2:0], 1'b0}
                      : {sh_arith & sh_val[XLEN-1], sh_val[XLEN-1:1]};
  end

  // Serial shifter datapath
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      sh_val   <= '0;
      sh_cnt   <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
    end else if (sh_state == SH_IDLE && accept && op_sshift) begin
      sh_val   <= I_dataS1;
      sh_cnt   <= shamt;
      sh_left  <= (I_aluop == ALUOP_SLL);
      sh_arith <= (I_aluop == ALUOP_SRA);
    end else if (sh_state == SH_RUN) begin
      sh_val <= sh_step;
      sh_cnt <= sh_cnt - 1'b1;
    end
  end

  spu32_cpu_divider #(.XLEN(XLEN)) u_div (
    .clk       (I_clk),
    .reset     (I_reset),
    .start     (accept && op_div),
    .signed_op (div_signed),
    .dividend  (I_dataS1),
    .divisor   (I_dataS2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_remd)
  );

  // Result write-back; at most one source completes on any edge
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      O_data      <= '0;
      O_valid     <= 1'b0;
      mul_pending <= 1'b0;
      mul_prod    <= '0;
      mul_high    <= 1'b0;
      div_rem     <= 1'b0;
    end else begin
      O_valid     <= 1'b0;
      mul_pending <= 1'b0;
      if (accept) begin
        if (op_mul) begin
          mul_prod    <= mul_full;
          mul_high    <= (I_aluop != ALUOP_MUL);
          mul_pending <= 1'b1;
        end else if (op_div) begin
          div_rem <= (I_aluop == ALUOP_REM) || (I_aluop == ALUOP_REMU);
        end else if (!op_sshift) begin
          O_data  <= alu_result;
          O_valid <= 1'b1;
        end
      end
      if (mul_pending) begin
        O_data  <= mul_high ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
        O_valid <= 1'b1;
      end
      if (div_done) begin
        O_data  <= div_rem ? div_remd : div_quot;
        O_valid <= 1'b1;
      end
      if (sh_done) begin
        O_data  <= sh_step;
        O_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spu32_cpu_alu_ext.sv
// Bench for spu32_cpu_alu_ext: a barrel-shift instance and a serial-shift
// instance share all inputs except I_en. Each request is followed for a
// fixed window; result, latency, busy cycles and pulse count are compared
// against a reference computed from the RISC-V arithmetic rules.
module tb_spu32_cpu_alu_ext;
  import spu32_cpu_alu_ext_pkg::*;

  localparam int XLEN = 32;
  localparam int WIN  = 40;

  logic            clk;
  logic            rst;
  logic [1:0]      en;
  logic [4:0]      aluop;
  logic [XLEN-1:0] s1, s2;
  logic [1:0]      busy, valid, lt, ltu, eq;
  logic [XLEN-1:0] data [2];

  int n_cmp  = 0;
  int n_fail = 0;

  spu32_cpu_alu_ext #(.XLEN(XLEN), .SERIAL_SHIFT(0), .ENABLE_DIV(1)) u_bar (
    .I_clk(clk), .I_reset(rst), .I_en(en[0]), .I_aluop(aluop),
    .I_dataS1(s1), .I_dataS2(s2), .O_busy(busy[0]), .O_valid(valid[0]),
    .O_data(data[0]), .O_lt(lt[0]), .O_ltu(ltu[0]), .O_eq(eq[0])
  );

  spu32_cpu_alu_ext #(.XLEN(XLEN), .SERIAL_SHIFT(1), .ENABLE_DIV(1)) u_ser (
    .I_clk(clk), .I_reset(rst), .I_en(en[1]), .I_aluop(aluop),
    .I_dataS1(s1), .I_dataS2(s2), .O_busy(busy[1]), .O_valid(valid[1]),
    .O_data(data[1]), .O_lt(lt[1]), .O_ltu(ltu[1]), .O_eq(eq[1])
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result from the RV32IM definitions
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    logic [63:0]     pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      ALUOP_SUB:    return a - b;
      ALUOP_AND:    return a & b;
      ALUOP_OR:     return a | b;
      ALUOP_XOR:    return a ^ b;
      ALUOP_SLT:    return {31'b0, sa < sb};
      ALUOP_SLTU:   return {31'b0, a < b};
      ALUOP_SLL:    return a << b[4:0];
      ALUOP_SRL:    return a >> b[4:0];
      ALUOP_SRA:    return $signed(a) >>> b[4:0];
      ALUOP_MUL:    begin p = sa * sb; return p[31:0]; end
      ALUOP_MULH:   begin p = sa * sb; return p[63:32]; end
      ALUOP_MULHSU: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      ALUOP_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      ALUOP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      ALUOP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALUOP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      ALUOP_REMU:   return (b == 0) ? a : a % b;
      default:      return a + b;
    endcase
  endfunction

  // Clocks from the accept edge until O_valid is seen (1 = cycle right after it)
  function automatic int latency(input int inst, input logic [4:0] op, input logic [31:0] b);
    if (op inside {ALUOP_MUL, ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU}) return 2;
    if (op inside {ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU}) return XLEN + 2;
    if (inst == 1 && op inside {ALUOP_SLL, ALUOP_SRL, ALUOP_SRA} && b[4:0] != 0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issue one request to both instances and follow it for WIN cycles.
  // inject_at > 0 raises I_en (as an ADD) at that cycle on instances still busy.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int inject_at);
    int   lat[2], first_v[2], nvalid[2], nbusy[2];
    logic [31:0] got[2];
    for (int i = 0; i < 2; i++) begin
      lat[i] = latency(i, op, b);
      first_v[i] = -1; nvalid[i] = 0; nbusy[i] = 0; got[i] = 'x;
    end
    @(negedge clk);
    aluop = op; s1 = a; s2 = b; en = 2'b11;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("%s flags%0d", tag, i), {61'b0, lt[i], ltu[i], eq[i]},
            {61'b0, $signed(a) < $signed(b), a < b, a == b});
    @(negedge clk);
    en = 2'b00; aluop = 5'($urandom); s1 = $urandom; s2 = $urandom;
    for (int c = 1; c <= WIN; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) nbusy[i]++;
        if (valid[i]) begin
          nvalid[i]++;
          if (first_v[i] < 0) begin first_v[i] = c; got[i] = data[i]; end
        end
      end
      en = 2'b00;
      if (c == inject_at) begin
        aluop = ALUOP_ADD;
        for (int i = 0; i < 2; i++) if (c < lat[i]) en[i] = 1'b1;
      end
      @(negedge clk);
    end
    en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s data%0d", tag, i), {32'b0, got[i]}, {32'b0, exp});
      check($sformatf("%s lat%0d", tag, i), 64'(first_v[i]), 64'(lat[i]));
      check($sformatf("%s pulses%0d", tag, i), 64'(nvalid[i]), 64'd1);
      check($sformatf("%s busy%0d", tag, i), 64'(nbusy[i]), 64'(lat[i] - 1));
      check($sformatf("%s held%0d", tag, i), {32'b0, data[i]}, {32'b0, exp});
    end
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    int          nv;

    // Reset
    rst = 1'b1; en = 2'b00; aluop = ALUOP_ADD; s1 = '0; s2 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset busy%0d", i), {63'b0, busy[i]}, 64'd0);
      check($sformatf("reset valid%0d", i), {63'b0, valid[i]}, 64'd0);
      check($sformatf("reset data%0d", i), {32'b0, data[i]}, 64'd0);
    end
    rst = 1'b0;

    // Directed cases
    do_op("add_ovf",  ALUOP_ADD,    32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 0);
    do_op("div_ovf",  ALUOP_DIV,    32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 0);
    do_op("rem_ovf",  ALUOP_REM,    32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         0);
    do_op("divu_z",   ALUOP_DIVU,   32'd100,       32'd0,          32'hFFFF_FFFF, 0);
    do_op("remu_z",   ALUOP_REMU,   32'd100,       32'd0,          32'd100,       0);
    do_op("div_m7",   ALUOP_DIV,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 20);
    do_op("rem_m7",   ALUOP_REM,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 0);
    do_op("div_negz", ALUOP_DIV,    32'h8000_0005, 32'd0,          32'hFFFF_FFFF, 0);
    do_op("rem_negz", ALUOP_REM,    32'h8000_0005, 32'd0,          32'h8000_0005, 0);
    do_op("sra31",    ALUOP_SRA,    32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 5);
    do_op("sll0",     ALUOP_SLL,    32'h1234_5678, 32'd0,          32'h1234_5678, 0);
    do_op("srl4",     ALUOP_SRL,    32'hF000_000F, 32'd4,          32'h0F00_0000, 0);
    do_op("mulhsu",   ALUOP_MULHSU, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 1);
    do_op("mulhu",    ALUOP_MULHU,  32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 0);
    do_op("mulh",     ALUOP_MULH,   32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 0);
    do_op("mul",      ALUOP_MUL,    32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFE, 0);
    do_op("slt",      ALUOP_SLT,    32'hFFFF_FFFF, 32'd1,          32'd1,         0);
    do_op("sltu",     ALUOP_SLTU,   32'hFFFF_FFFF, 32'd1,          32'd0,         0);
    do_op("sub",      ALUOP_SUB,    32'd0,         32'd1,          32'hFFFF_FFFF, 0);
    do_op("unknown",  5'd25,        32'd10,        32'd20,         32'd30,        0);

    // Reset ten cycles into a division aborts it silently
    @(negedge clk);
    aluop = ALUOP_DIV; s1 = $urandom; s2 = $urandom_range(1, 1000); en = 2'b11;
    @(negedge clk);
    en = 2'b00;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort busy%0d", i), {63'b0, busy[i]}, 64'd0);
      check($sformatf("abort data%0d", i), {32'b0, data[i]}, 64'd0);
      check($sformatf("abort valid%0d", i), {63'b0, valid[i]}, 64'd0);
    end
    nv = 0;
    for (int c = 0; c < WIN; c++) begin
      if (valid != 2'b00) nv++;
      @(negedge clk);
    end
    check("abort no_valid", 64'(nv), 64'd0);
    do_op("add_after", ALUOP_ADD, 32'd3, 32'd4, 32'd7, 0);

    // Reset and request on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1; en = 2'b11; aluop = ALUOP_ADD; s1 = 32'd5; s2 = 32'd6;
    @(negedge clk);
    rst = 1'b0; en = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_en valid%0d", i), {63'b0, valid[i]}, 64'd0);
      check($sformatf("rst_en data%0d", i), {32'b0, data[i]}, 64'd0);
    end

    // Randomized requests against the reference
    for (int k = 0; k < 60; k++) begin
      op = 5'($urandom_range(0, 31));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(0, 3);
        default: ;
      endcase
      do_op($sformatf("rnd%0d_op%0d", k, op), op, a, b, model(op, a, b),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
